// File: rtl/ifm_loader_pkg.sv
// Shared constants and state encoding for the layer00 IFM BRAM loader.
// Optional build macro: IFM_CHECKSUM_EN (adds a pixel checksum output).
package ifm_loader_pkg;

  localparam int NUM_BANKS    = 16;
  localparam int BANK_DEPTH   = 128;
  localparam int ADDR_W       = 9;
  localparam int PIX_W        = 32;
  localparam int PIX_PER_WORD = 4;
  localparam int DATA_W       = PIX_W * PIX_PER_WORD;
  localparam int BIAS_W       = 16;
  localparam int NUM_BIAS     = 4;
  localparam int CNT_W        = 2;
  localparam int TOTAL_BEATS  = NUM_BANKS * BANK_DEPTH * PIX_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_IFM,
    ST_LOAD_BIAS,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ifm_word_packer.sv
// Packs 4 x 32-bit pixel beats into one 128-bit word, first beat in [31:0].
// Emits a one-cycle registered write-valid alongside the packed word.
module ifm_word_packer
  import ifm_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              beat_i,
  input  logic [PIX_W-1:0]  data_i,
  output logic              last_o,
  output logic              wr_vld_o,
  output logic [DATA_W-1:0] word_o
);

  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_W-PIX_W-1:0] acc_q;
  logic [DATA_W-1:0]       word_q;
  logic                    vld_q;

  assign last_o   = beat_i && (cnt_q == CNT_W'(PIX_PER_WORD - 1));
  assign wr_vld_o = vld_q;
  assign word_o   = word_q;

  // Beats shift in from the top so the oldest ends up in the low lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= last_o && !clear_i;
      if (clear_i) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (beat_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_o) begin
          word_q <= {data_i, acc_q};
        end else begin
          acc_q <= {data_i, acc_q[DATA_W-PIX_W-1:PIX_W]};
        end
      end
    end
  end

endmodule

// File: rtl/ifm_bram_loader.sv
// Streams IFM pixels into layer00's 16 BRAM banks, captures biases, starts layer00.
// Optional build macro: IFM_CHECKSUM_EN adds oChecksum (sum of accepted pixels).
module ifm_bram_loader
  import ifm_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iLoadStart,
  input  logic                 iPixValid,
  input  logic [PIX_W-1:0]     iPixData,
  output logic                 oPixReady,
  input  logic                 iBiasValid,
  input  logic [BIAS_W-1:0]    iBiasData,
  output logic                 oBiasReady,
  output logic [NUM_BANKS-1:0] o_ena,
  output logic [NUM_BANKS-1:0] o_wea,
  output logic [ADDR_W-1:0]    o_addra,
  output logic [DATA_W-1:0]    o_dia,
  output logic [BIAS_W-1:0]    oBias0,
  output logic [BIAS_W-1:0]    oBias1,
  output logic [BIAS_W-1:0]    oBias2,
  output logic [BIAS_W-1:0]    oBias3,
`ifdef IFM_CHECKSUM_EN
  output logic [31:0]          oChecksum,
`endif
  output logic                 oStart,
  output logic                 oBusy
);

  state_e                 state_q;
  logic                   pix_rdy_q;
  logic                   bias_rdy_q;
  logic                   busy_q;
  logic                   start_q;
  logic                   fin_q;
  logic [NUM_BANKS-1:0]   bank_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [NUM_BANKS-1:0]   ena_q;
  logic [ADDR_W-1:0]      addra_q;
  logic [CNT_W-1:0]       bidx_q;
  logic [BIAS_W-1:0]      bias_q [NUM_BIAS];

  logic                   pix_acc;
  logic                   bias_acc;
  logic                   start_ok;
  logic                   pk_last;
  logic                   pk_vld;
  logic                   addr_end;
  logic                   last_word;

  assign pix_acc   = iPixValid && pix_rdy_q;
  assign bias_acc  = iBiasValid && bias_rdy_q;
  assign start_ok  = iLoadStart &&
                     (state_q == ST_IDLE || state_q == ST_DONE);
  assign addr_end  = (addr_q == ADDR_W'(BANK_DEPTH - 1));
  assign last_word = bank_q[NUM_BANKS-1] && addr_end;

  ifm_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start_ok),
    .beat_i   (pix_acc),
    .data_i   (iPixData),
    .last_o   (pk_last),
    .wr_vld_o (pk_vld),
    .word_o   (o_dia)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pix_rdy_q  <= 1'b0;
      bias_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      fin_q      <= 1'b0;
      bank_q     <= '0;
      addr_q     <= '0;
      ena_q      <= '0;
      addra_q    <= '0;
      bidx_q     <= '0;
      for (int i = 0; i < NUM_BIAS; i++) bias_q[i] <= '0;
    end else begin
      ena_q <= '0;
      // Latch the write target on the 4th beat; it is driven with the word.
      if (pk_last) begin
        ena_q   <= bank_q;
        addra_q <= addr_q;
        if (addr_end) begin
          addr_q <= '0;
          bank_q <= {bank_q[NUM_BANKS-2:0], 1'b0};
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
        if (last_word) begin
          pix_rdy_q <= 1'b0;
          fin_q     <= 1'b1;
        end
      end
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (iLoadStart) begin
            state_q   <= ST_LOAD_IFM;
            pix_rdy_q <= 1'b1;
            busy_q    <= 1'b1;
            start_q   <= 1'b0;
            fin_q     <= 1'b0;
            bank_q    <= NUM_BANKS'(1);
            addr_q    <= '0;
            bidx_q    <= '0;
          end
        end
        ST_LOAD_IFM: begin
          if (fin_q) begin
            state_q    <= ST_LOAD_BIAS;
            fin_q      <= 1'b0;
            bias_rdy_q <= 1'b1;
            bidx_q     <= '0;
          end
        end
        ST_LOAD_BIAS: begin
          if (bias_acc) begin
            bias_q[bidx_q] <= iBiasData;
            bidx_q         <= bidx_q + CNT_W'(1);
            if (bidx_q == CNT_W'(NUM_BIAS - 1)) begin
              state_q    <= ST_DONE;
              bias_rdy_q <= 1'b0;
              busy_q     <= 1'b0;
              start_q    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef IFM_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (pix_acc) begin
      csum_q <= csum_q + 32'(iPixData);
    end
  end

  assign oChecksum = csum_q;
`endif

  assign oPixReady  = pix_rdy_q;
  assign oBiasReady = bias_rdy_q;
  assign o_ena      = pk_vld ? ena_q : '0;
  assign o_wea      = pk_vld ? ena_q : '0;
  assign o_addra    = addra_q;
  assign oBias0     = bias_q[0];
  assign oBias1     = bias_q[1];
  assign oBias2     = bias_q[2];
  assign oBias3     = bias_q[3];
  assign oStart     = start_q;
  assign oBusy      = busy_q;

endmodule

// File: tb/tb_ifm_bram_loader.sv
// Scoreboard bench for ifm_bram_loader: expected BRAM writes are queued by
// the stimulus and popped by a negedge monitor whenever o_ena pulses.
`timescale 1ns/1ps
module tb_ifm_bram_loader;

  logic          clk = 1'b0;
  logic          rst;
  logic          iLoadStart;
  logic          iPixValid;
  logic [31:0]   iPixData;
  logic          oPixReady;
  logic          iBiasValid;
  logic [15:0]   iBiasData;
  logic          oBiasReady;
  logic [15:0]   o_ena;
  logic [15:0]   o_wea;
  logic [8:0]    o_addra;
  logic [127:0]  o_dia;
  logic [15:0]   oBias0, oBias1, oBias2, oBias3;
  logic          oStart;
  logic          oBusy;
`ifdef IFM_CHECKSUM_EN
  logic [31:0]   oChecksum;
`endif

  ifm_bram_loader dut (
    .clk        (clk),
    .rst        (rst),
    .iLoadStart (iLoadStart),
    .iPixValid  (iPixValid),
    .iPixData   (iPixData),
    .oPixReady  (oPixReady),
    .iBiasValid (iBiasValid),
    .iBiasData  (iBiasData),
    .oBiasReady (oBiasReady),
    .o_ena      (o_ena),
    .o_wea      (o_wea),
    .o_addra    (o_addra),
    .o_dia      (o_dia),
    .oBias0     (oBias0),
    .oBias1     (oBias1),
    .oBias2     (oBias2),
    .oBias3     (oBias3),
`ifdef IFM_CHECKSUM_EN
    .oChecksum  (oChecksum),
`endif
    .oStart     (oStart),
    .oBusy      (oBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  ena;
    logic [8:0]   addr;
    logic [127:0] dia;
  } wr_t;

  wr_t          sbq[$];
  int           n_cmp = 0;
  int           n_mis = 0;
  int           log_n = 0;
  logic [15:0]  log_ena  [2048];
  logic [8:0]   log_addr [2048];
  logic [127:0] log_dia  [2048];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (o_ena != 16'h0) begin
      if (log_n < 2048) begin
        log_ena[log_n]  = o_ena;
        log_addr[log_n] = o_addra;
        log_dia[log_n]  = o_dia;
      end
      log_n++;
      chk("wea_eq_ena", o_wea, o_ena);
      if (sbq.size() == 0) begin
        chk("unexpected_write", o_ena, 16'h0);
      end else begin
        e = sbq.pop_front();
        chk("wr_ena", o_ena, e.ena);
        chk("wr_addr", o_addra, e.addr);
        chk("wr_dia", o_dia, e.dia);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    log_n = 0;
  endtask

  task automatic send_pix(input logic [31:0] d, input int gap);
    bit acc = 1'b0;
    iPixValid = 1'b1;
    iPixData  = d;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = oPixReady;
      tick();
    end
    iPixValid = 1'b0;
    if (!acc) chk("pix_accept_timeout", oPixReady, 1'b1);
    repeat (gap) tick();
  endtask

  task automatic send_bias(input logic [15:0] d);
    bit acc = 1'b0;
    iBiasValid = 1'b1;
    iBiasData  = d;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = oBiasReady;
      tick();
    end
    iBiasValid = 1'b0;
    if (!acc) chk("bias_accept_timeout", oBiasReady, 1'b1);
  endtask

  task automatic run_load(input int base, input int gap,
                          input int nbeats, input int ls_at);
    logic [15:0] one = 16'h0001;
    wr_t e;
    for (int i = 0; i < nbeats; i++) begin
      if (i % 4 == 0) begin
        e.ena  = one << ((i / 4) / 128);
        e.addr = 9'((i / 4) % 128);
        e.dia  = {32'(base + i + 3), 32'(base + i + 2),
                  32'(base + i + 1), 32'(base + i)};
        sbq.push_back(e);
      end
      if (i == ls_at) iLoadStart = 1'b1;
      send_pix(32'(base + i), gap);
      iLoadStart = 1'b0;
    end
  endtask

  task automatic drain_check(input string nm);
    repeat (4) tick();
    chk({nm, "_queue_empty"}, 128'(sbq.size()), 0);
    chk({nm, "_write_count"}, 128'(log_n), 2048);
  endtask

  initial begin
    rst = 1'b1;
    iLoadStart = 1'b0;
    iPixValid = 1'b0;
    iPixData = '0;
    iBiasValid = 1'b0;
    iBiasData = '0;
    repeat (3) tick();
    chk("rst_ena", o_ena, 0);
    chk("rst_wea", o_wea, 0);
    chk("rst_addra", o_addra, 0);
    chk("rst_dia", o_dia, 0);
    chk("rst_bias", {oBias0, oBias1, oBias2, oBias3}, 0);
    chk("rst_ctl", {oStart, oBusy, oPixReady, oBiasReady}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    iPixValid = 1'b1;
    iBiasValid = 1'b1;
    repeat (5) tick();
    chk("idle_pix_ready", oPixReady, 0);
    chk("idle_bias_ready", oBiasReady, 0);
    iPixValid = 1'b0;
    iBiasValid = 1'b0;

    start_load();
    chk("start_busy", oBusy, 1);
    chk("start_pix_ready", oPixReady, 1);
    run_load(0, 0, 300, -1);
    @(negedge clk);
    #1;
    chk("mid_queue_empty", 128'(sbq.size()), 0);
    rst = 1'b1;
    #1;
    chk("midrst_ena", o_ena, 0);
    chk("midrst_addra", o_addra, 0);
    chk("midrst_dia", o_dia, 0);
    chk("midrst_ctl", {oStart, oBusy, oPixReady, oBiasReady}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("midrst_idle", {oBusy, oPixReady}, 0);

    start_load();
    run_load(300, 0, 8192, -1);
    drain_check("base300");
    chk("b300_first_ena", log_ena[0], 16'h0001);
    chk("b300_first_addr", log_addr[0], 0);
    chk("b300_first_dia", log_dia[0],
        128'h0000012F_0000012E_0000012D_0000012C);
    send_bias(16'h0001);
    send_bias(16'h0002);
    send_bias(16'h0003);
    send_bias(16'h0004);
    chk("b300_start", oStart, 1);
    chk("b300_bias", {oBias0, oBias1, oBias2, oBias3},
        64'h0001_0002_0003_0004);

    start_load();
    chk("restart_start_low", oStart, 0);
    chk("restart_busy", oBusy, 1);
    chk("restart_bias_kept", oBias0, 16'h0001);
    iBiasValid = 1'b1;
    iBiasData = 16'hDEAD;
    run_load(0, 0, 8192, 1000);
    iBiasValid = 1'b0;
    chk("cont_pix_ready_low", oPixReady, 0);
    drain_check("cont");
    chk("cont_first_ena", log_ena[0], 16'h0001);
    chk("cont_first_addr", log_addr[0], 0);
    chk("cont_first_dia", log_dia[0],
        128'h00000003_00000002_00000001_00000000);
    chk("cont_b1_ena", log_ena[128], 16'h0002);
    chk("cont_b1_addr", log_addr[128], 0);
    chk("cont_b1_dia", log_dia[128],
        128'h00000203_00000202_00000201_00000200);
    chk("cont_last_ena", log_ena[2047], 16'h8000);
    chk("cont_last_addr", log_addr[2047], 127);
    chk("cont_last_dia", log_dia[2047],
        128'h00001FFF_00001FFE_00001FFD_00001FFC);
    chk("cont_bias_ignored", oBias0, 16'h0001);
    chk("cont_bias_ready", oBiasReady, 1);
    chk("cont_busy", oBusy, 1);
`ifdef IFM_CHECKSUM_EN
    chk("checksum", oChecksum, 32'h01FFF000);
`endif
    send_bias(16'h0010);
    send_bias(16'hFFF0);
    send_bias(16'h0123);
    chk("bias_not_started", oStart, 0);
    send_bias(16'h8000);
    chk("bias_start", oStart, 1);
    chk("bias_busy_low", oBusy, 0);
    chk("bias_vals", {oBias0, oBias1, oBias2, oBias3},
        64'h0010_FFF0_0123_8000);
`ifdef IFM_CHECKSUM_EN
    chk("checksum_frozen", oChecksum, 32'h01FFF000);
`endif

    start_load();
    run_load(0, 1, 8192, -1);
    drain_check("thr");
    chk("thr_first_dia", log_dia[0],
        128'h00000003_00000002_00000001_00000000);
    chk("thr_last_dia", log_dia[2047],
        128'h00001FFF_00001FFE_00001FFD_00001FFC);
    send_bias(16'h0A0A);
    send_bias(16'h0B0B);
    send_bias(16'h0C0C);
    send_bias(16'h0D0D);
    chk("thr_start", oStart, 1);
    chk("thr_bias", {oBias0, oBias1, oBias2, oBias3},
        64'h0A0A_0B0B_0C0C_0D0D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
